multicycle_control_unit: RTL and testbench



---
 rtl/mcu_pkg.sv | 60 ++++++
 rtl/mcu_wait_timer.sv | 42 ++++
 rtl/multicycle_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the multi-cycle control unit.
//   - MIPS-subset opcode constants
//   - FSM state enumeration
//   - alu_op, alu_src_b and pc_source encodings
//   - small helper functions used by the control FSM
package mcu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP,
    ST_HALT
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_VEC    = 2'b11;

  // States that wait on mem_ready and run the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  function automatic logic is_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDIU,
                      OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// mcu_wait_timer: bounded mem_ready wait counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the counter (asserted on every state change)
//   count      : current state is waiting on memory
//   ready      : mem_ready from the memory
//   expired    : counter at MAX_WAIT with ready still low (timeout this cycle)
module mcu_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              at_max;

  assign at_max  = (cnt_q == WAIT_W'(MAX_WAIT));
  assign expired = count && !ready && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !ready && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS-subset control FSM.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives
// the datapath enables for the current state; memory states handshake on
// mem_ready with a bounded wait (timeout -> HALT, sticky mem_timeout).
//   clk, reset          : clock, synchronous active-high reset
//   opcode              : IR[31:26], valid from DECODE onward
//   mem_ready           : memory access complete this cycle
//   pc_write, pc_write_cond, branch_ne, pc_source : PC update control
//   iord, mem_read, mem_write, ir_write           : memory / IR control
//   mem_to_reg, reg_dst, reg_write                : register file control
//   alu_src_a, alu_src_b, alu_op                  : ALU control
//   instr_done          : pulse on the last cycle of each instruction
//   mem_timeout         : sticky memory timeout flag
//   illegal_op          : only with ILLEGAL_TRAP_EN defined; asserted in TRAP
// Macro ILLEGAL_TRAP_EN: unsupported opcodes trap to the exception vector
// (pc_source=11) instead of executing as a NOP.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic               mem_timeout
);

  state_e state_q, state_d;
  logic   mem_timeout_q;
  logic   tmr_expired;

  mcu_wait_timer #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .count  (is_wait_state(state_q)),
    .ready  (mem_ready),
    .expired(tmr_expired)
  );

  // State register and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_q | tmr_expired;
    end
  end

  assign mem_timeout = mem_timeout_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (tmr_expired)    state_d = ST_HALT;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_d = ST_EXEC_R;
          OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = ST_BRANCH;
          OP_J:                     state_d = ST_JUMP;
          OP_ADDIU, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
`ifdef ILLEGAL_TRAP_EN
          default:                  state_d = ST_TRAP;
`else
          default:                  state_d = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (tmr_expired)    state_d = ST_HALT;
        else if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WR: begin
        if (tmr_expired)    state_d = ST_HALT;
        else if (mem_ready) state_d = ST_FETCH;
      end
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Output decode: state-based, plus the mem_ready-qualified FETCH/MEM_WR
  // pulses and the opcode-qualified DECODE/EXEC_I/BRANCH fields.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALU_ADD);
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
`ifndef ILLEGAL_TRAP_EN
        instr_done = !is_supported(opcode);
`endif
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      ST_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_ADDIU) ? ALUOP_W'(ALU_ADD) : ALUOP_W'(ALU_IMM);
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
        pc_write   = 1'b1;
        pc_source  = PCSRC_VEC;
        instr_done = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed stimulus with an expected-output
// scoreboard; every cycle's expected control vector is queued when the
// inputs are driven and compared at the following falling edge.
module tb_multicycle_control_unit;

  localparam logic [5:0] T_RTYPE = 6'h00;
  localparam logic [5:0] T_J     = 6'h02;
  localparam logic [5:0] T_BEQ   = 6'h04;
  localparam logic [5:0] T_BNE   = 6'h05;
  localparam logic [5:0] T_ADDIU = 6'h09;
  localparam logic [5:0] T_ANDI  = 6'h0C;
  localparam logic [5:0] T_ORI   = 6'h0D;
  localparam logic [5:0] T_LW    = 6'h23;
  localparam logic [5:0] T_SW    = 6'h2B;
  localparam logic [5:0] T_BAD   = 6'h3F;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       mem_timeout;
  } ov_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, mem_timeout;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int  checks = 0;
  int  passes = 0;
  int  fails  = 0;
  ov_t exp_q[$];

  multicycle_control_unit #(
    .OP_W    (6),
    .ALUOP_W (2),
    .WAIT_W  (4),
    .MAX_WAIT(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne    (branch_ne),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .instr_done   (instr_done),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op   (illegal_op),
`endif
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected control vectors, one per state, written from the state table.
  function automatic ov_t f_fetch(input logic r);
    ov_t v = '0;
    v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = r; v.pc_write = r;
    return v;
  endfunction
  function automatic ov_t f_decode(input logic nop);
    ov_t v = '0;
    v.alu_src_b = 2'b11; v.instr_done = nop;
    return v;
  endfunction
  function automatic ov_t f_exec_r();
    ov_t v = '0;
    v.alu_src_a = 1'b1; v.alu_op = 2'b10;
    return v;
  endfunction
  function automatic ov_t f_r_wb();
    ov_t v = '0;
    v.reg_dst = 1'b1; v.reg_write = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_exec_i(input logic [1:0] aop);
    ov_t v = '0;
    v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = aop;
    return v;
  endfunction
  function automatic ov_t f_i_wb();
    ov_t v = '0;
    v.reg_write = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_mem_addr();
    ov_t v = '0;
    v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
    return v;
  endfunction
  function automatic ov_t f_mem_rd();
    ov_t v = '0;
    v.mem_read = 1'b1; v.iord = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_mem_wb();
    ov_t v = '0;
    v.mem_to_reg = 1'b1; v.reg_write = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_mem_wr(input logic r);
    ov_t v = '0;
    v.mem_write = 1'b1; v.iord = 1'b1; v.instr_done = r;
    return v;
  endfunction
  function automatic ov_t f_branch(input logic ne);
    ov_t v = '0;
    v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_write_cond = 1'b1;
    v.pc_source = 2'b01; v.branch_ne = ne; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_jump();
    ov_t v = '0;
    v.pc_write = 1'b1; v.pc_source = 2'b10; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_halt();
    ov_t v = '0;
    v.mem_timeout = 1'b1;
    return v;
  endfunction
  function automatic ov_t f_trap();
    ov_t v = '0;
    v.pc_write = 1'b1; v.pc_source = 2'b11; v.instr_done = 1'b1;
    return v;
  endfunction

  task automatic check_now(input string tag);
    ov_t e;
    ov_t o;
    o = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
         alu_op, pc_source, instr_done, mem_timeout};
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) passes++;
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  // Drive one cycle of inputs (just after the rising edge), queue the
  // expected outputs, compare at the falling edge.
  task automatic step(input logic [5:0] op, input logic rdy, input ov_t e,
                      input string tag);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset state: FETCH outputs, no timeout.
    step(T_RTYPE, 1'b0, f_fetch(1'b0), "reset_fetch");
    reset = 1'b0;

    // R-type add, zero wait states: 4 cycles.
    step(T_RTYPE, 1'b1, f_fetch(1'b1), "add_fetch");
    step(T_RTYPE, 1'b1, f_decode(1'b0), "add_decode");
    step(T_RTYPE, 1'b1, f_exec_r(), "add_exec");
    step(T_RTYPE, 1'b1, f_r_wb(), "add_wb");

    // lw with three wait cycles in MEM_RD: 8 cycles.
    step(T_LW, 1'b1, f_fetch(1'b1), "lw_fetch");
    step(T_LW, 1'b0, f_decode(1'b0), "lw_decode");
    step(T_LW, 1'b0, f_mem_addr(), "lw_addr");
    for (int i = 0; i < 3; i++) step(T_LW, 1'b0, f_mem_rd(), "lw_rd_wait");
    step(T_LW, 1'b1, f_mem_rd(), "lw_rd_done");
    step(T_LW, 1'b0, f_mem_wb(), "lw_wb");

    // sw with one wait cycle in MEM_WR.
    step(T_SW, 1'b1, f_fetch(1'b1), "sw_fetch");
    step(T_SW, 1'b1, f_decode(1'b0), "sw_decode");
    step(T_SW, 1'b1, f_mem_addr(), "sw_addr");
    step(T_SW, 1'b0, f_mem_wr(1'b0), "sw_wr_wait");
    step(T_SW, 1'b1, f_mem_wr(1'b1), "sw_wr_done");

    // bne with two FETCH wait states, then beq.
    step(T_BNE, 1'b0, f_fetch(1'b0), "bne_fetch_wait");
    step(T_BNE, 1'b0, f_fetch(1'b0), "bne_fetch_wait");
    step(T_BNE, 1'b1, f_fetch(1'b1), "bne_fetch");
    step(T_BNE, 1'b1, f_decode(1'b0), "bne_decode");
    step(T_BNE, 1'b1, f_branch(1'b1), "bne_branch");
    step(T_BEQ, 1'b1, f_fetch(1'b1), "beq_fetch");
    step(T_BEQ, 1'b0, f_decode(1'b0), "beq_decode");
    step(T_BEQ, 1'b0, f_branch(1'b0), "beq_branch");

    // j: 3 cycles.
    step(T_J, 1'b1, f_fetch(1'b1), "j_fetch");
    step(T_J, 1'b1, f_decode(1'b0), "j_decode");
    step(T_J, 1'b1, f_jump(), "j_jump");

    // I-type ALU ops: addiu uses add, andi/ori use immediate-logic.
    step(T_ADDIU, 1'b1, f_fetch(1'b1), "addiu_fetch");
    step(T_ADDIU, 1'b0, f_decode(1'b0), "addiu_decode");
    step(T_ADDIU, 1'b1, f_exec_i(2'b00), "addiu_exec");
    step(T_ADDIU, 1'b0, f_i_wb(), "addiu_wb");
    step(T_ANDI, 1'b1, f_fetch(1'b1), "andi_fetch");
    step(T_ANDI, 1'b1, f_decode(1'b0), "andi_decode");
    step(T_ANDI, 1'b1, f_exec_i(2'b11), "andi_exec");
    step(T_ANDI, 1'b1, f_i_wb(), "andi_wb");
    step(T_ORI, 1'b1, f_fetch(1'b1), "ori_fetch");
    step(T_ORI, 1'b1, f_decode(1'b0), "ori_decode");
    step(T_ORI, 1'b1, f_exec_i(2'b11), "ori_exec");
    step(T_ORI, 1'b1, f_i_wb(), "ori_wb");

    // Unsupported opcode.
    step(T_BAD, 1'b1, f_fetch(1'b1), "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(T_BAD, 1'b1, f_decode(1'b0), "bad_decode");
    opcode    = T_BAD;
    mem_ready = 1'b1;
    exp_q.push_back(f_trap());
    @(negedge clk);
    check_now("bad_trap");
    checks++;
    assert (illegal_op === 1'b1) passes++;
    else begin
      fails++;
      $error("FAIL illegal_op: observed %b expected 1", illegal_op);
    end
    @(posedge clk);
    #1;
`else
    step(T_BAD, 1'b1, f_decode(1'b1), "bad_nop");
`endif
    step(T_J, 1'b1, f_fetch(1'b1), "after_bad_fetch");
    step(T_J, 1'b1, f_decode(1'b0), "after_bad_decode");
    step(T_J, 1'b1, f_jump(), "after_bad_jump");

    // Boundary: 15 wait cycles then ready on the 16th does not time out.
    for (int i = 0; i < 15; i++) step(T_J, 1'b0, f_fetch(1'b0), "fetch_wait15");
    step(T_J, 1'b1, f_fetch(1'b1), "fetch_ready_at_max");
    step(T_J, 1'b1, f_decode(1'b0), "max_decode");
    step(T_J, 1'b1, f_jump(), "max_jump");

    // Reset in the middle of a MEM_RD wait.
    step(T_LW, 1'b1, f_fetch(1'b1), "lw2_fetch");
    step(T_LW, 1'b1, f_decode(1'b0), "lw2_decode");
    step(T_LW, 1'b1, f_mem_addr(), "lw2_addr");
    for (int i = 0; i < 5; i++) step(T_LW, 1'b0, f_mem_rd(), "lw2_rd_wait");
    reset = 1'b1;
    step(T_LW, 1'b0, f_mem_rd(), "lw2_rd_reset");
    reset = 1'b0;

    // Counter must be cleared by that reset: 15 more waits still legal.
    for (int i = 0; i < 15; i++) step(T_J, 1'b0, f_fetch(1'b0), "post_reset_wait");
    step(T_J, 1'b1, f_fetch(1'b1), "post_reset_ready");
    step(T_J, 1'b1, f_decode(1'b0), "post_reset_decode");
    step(T_J, 1'b1, f_jump(), "post_reset_jump");

    // Timeout: 16th idle cycle in FETCH expires, then HALT.
    for (int i = 0; i < 16; i++) step(T_J, 1'b0, f_fetch(1'b0), "timeout_wait");
    step(T_J, 1'b1, f_halt(), "halt");
    step(T_LW, 1'b1, f_halt(), "halt_ignores_ready");
    step(T_SW, 1'b0, f_halt(), "halt_hold");
    reset = 1'b1;
    step(T_J, 1'b1, f_halt(), "halt_reset_cycle");
    reset = 1'b0;
    step(T_J, 1'b1, f_fetch(1'b1), "after_halt_fetch");
    step(T_J, 1'b1, f_decode(1'b0), "after_halt_decode");
    step(T_J, 1'b1, f_jump(), "after_halt_jump");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
